// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline register/control taps in, stall/flush/forward selects out.
// Performance counter signals exist only when HAZ_PERF_CNT_EN is defined.
interface hazard_ctrl_if
`ifdef HAZ_PERF_CNT_EN
    #(parameter int CNT_W = 32)
`endif
    ;
    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] Rs1E;
    logic [4:0] Rs2E;
    logic [4:0] RdE;
    logic [4:0] RdM;
    logic [4:0] RdW;
    logic       reg_writeM;
    logic       reg_writeW;
    logic       result_src0E;
    logic       PC_srcE;
    logic       mem_reqM;
    logic       mem_readyM;

    logic       stallF;
    logic       stallD;
    logic       stallE;
    logic       stallM;
    logic       flushD;
    logic       flushE;
    logic       flushW;
    logic [1:0] forwardAE;
    logic [1:0] forwardBE;
    logic       halt;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_cnt;
    logic [CNT_W-1:0] perf_flush_cnt;
`endif

    // Datapath side: drives pipeline taps, consumes control.
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output reg_writeM, reg_writeW, result_src0E, PC_srcE, mem_reqM, mem_readyM,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
        input  forwardAE, forwardBE, halt
`ifdef HAZ_PERF_CNT_EN
        , input perf_stall_cnt, perf_flush_cnt
`endif
    );

    // Hazard controller side.
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  reg_writeM, reg_writeW, result_src0E, PC_srcE, mem_reqM, mem_readyM,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
        output forwardAE, forwardBE, halt
`ifdef HAZ_PERF_CNT_EN
        , output perf_stall_cnt, perf_flush_cnt
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding, load-use interlock, branch flush,
// data-memory wait-state freeze with timeout halt. Optional counters under HAZ_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_ctrl_if.slave     bus,
    output logic [1:0]       dbg_state
);
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    if (MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_param_check
        $error("hazard_ctrl: MEM_TIMEOUT must be >= 2 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                lw_stall;
    logic                freeze;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                           input logic wr_m, input logic [4:0] rd_w,
                                           input logic wr_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0 && rs == rd_m && wr_m) begin
            sel = 2'b10;
        end else if (rs != 5'd0 && rs == rd_w && wr_w) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // freeze: the memory stage is blocked this cycle; it overrides branch and load-use control.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        freeze   = 1'b0;
        lw_stall = bus.result_src0E && (bus.RdE != 5'd0) &&
                   ((bus.Rs1D == bus.RdE) || (bus.Rs2D == bus.RdE));
        case (state_q)
            RUN: begin
                if (bus.mem_reqM && !bus.mem_readyM) begin
                    freeze  = 1'b1;
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (bus.mem_readyM) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else begin
                    freeze = 1'b1;
                    if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_d = HALT;
                    end else if (wait_q != '1) begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            HALT: begin
                freeze = 1'b1;
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Every control output is forced low while reset is asserted.
    always_comb begin
        bus.stallF    = 1'b0;
        bus.stallD    = 1'b0;
        bus.stallE    = 1'b0;
        bus.stallM    = 1'b0;
        bus.flushD    = 1'b0;
        bus.flushE    = 1'b0;
        bus.flushW    = 1'b0;
        bus.forwardAE = 2'b00;
        bus.forwardBE = 2'b00;
        bus.halt      = 1'b0;
        if (rst_n) begin
            bus.forwardAE = fwd_sel(bus.Rs1E, bus.RdM, bus.reg_writeM, bus.RdW, bus.reg_writeW);
            bus.forwardBE = fwd_sel(bus.Rs2E, bus.RdM, bus.reg_writeM, bus.RdW, bus.reg_writeW);
            bus.halt      = (state_q == HALT);
            if (freeze) begin
                bus.stallF = 1'b1;
                bus.stallD = 1'b1;
                bus.stallE = 1'b1;
                bus.stallM = 1'b1;
                bus.flushW = 1'b1;
            end else begin
                bus.stallF = lw_stall && !bus.PC_srcE;
                bus.stallD = lw_stall && !bus.PC_srcE;
                bus.flushD = bus.PC_srcE;
                bus.flushE = lw_stall || bus.PC_srcE;
            end
        end
    end

    assign dbg_state = state_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (state_q != HALT) begin
            if (bus.stallF) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (bus.flushE) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.perf_stall_cnt = stall_cnt_q;
    assign bus.perf_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios then randomized traffic against a
// cycle-level reference model of the hazard rules (counters checked with HAZ_PERF_CNT_EN).
module tb_hazard_ctrl;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

`ifdef HAZ_PERF_CNT_EN
    hazard_ctrl_if #(.CNT_W(CNT_W)) hif();
`else
    hazard_ctrl_if hif();
`endif

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(hif.slave),
        .dbg_state(dbg_state)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: length of the current blocked access and a halted flag.
    int               busy = 0;
    bit               halted = 1'b0;
    bit               frz_now = 1'b0;
    bit               exp_stallf_now = 1'b0;
    bit               exp_flushe_now = 1'b0;
    logic [CNT_W-1:0] exp_stall_cnt = '0;
    logic [CNT_W-1:0] exp_flush_cnt = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_model(input logic [4:0] rs);
        if (rs != 0 && rs == hif.RdM && hif.reg_writeM) return 2'b10;
        if (rs != 0 && rs == hif.RdW && hif.reg_writeW) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0;
        hif.RdE = 0; hif.RdM = 0; hif.RdW = 0;
        hif.reg_writeM = 0; hif.reg_writeW = 0; hif.result_src0E = 0;
        hif.PC_srcE = 0; hif.mem_reqM = 0; hif.mem_readyM = 1;
    endtask

    task automatic check_cycle();
        bit lw;
        bit pc;
        logic [3:0] st;
        logic [2:0] fl;
        pc = hif.PC_srcE;
        lw = hif.result_src0E && hif.RdE != 0 && (hif.Rs1D == hif.RdE || hif.Rs2D == hif.RdE);
        frz_now = halted || ((busy > 0 || hif.mem_reqM) && !hif.mem_readyM);
        if (frz_now) begin
            st = 4'b1111;
            fl = 3'b001;
        end else begin
            st = {lw && !pc, lw && !pc, 2'b00};
            fl = {pc, lw || pc, 1'b0};
        end
        exp_stallf_now = st[3];
        exp_flushe_now = fl[1];
        check("stall", {hif.stallF, hif.stallD, hif.stallE, hif.stallM}, st);
        check("flush", {hif.flushD, hif.flushE, hif.flushW}, fl);
        check("fwdA", hif.forwardAE, fwd_model(hif.Rs1E));
        check("fwdB", hif.forwardBE, fwd_model(hif.Rs2E));
        check("halt", hif.halt, halted);
        check("state", dbg_state, halted ? 2 : (busy > 0 ? 1 : 0));
`ifdef HAZ_PERF_CNT_EN
        check("perf_stall", hif.perf_stall_cnt, exp_stall_cnt);
        check("perf_flush", hif.perf_flush_cnt, exp_flush_cnt);
`endif
    endtask

    task automatic update_model();
        if (!halted) begin
            if (exp_stallf_now) exp_stall_cnt = exp_stall_cnt + 1'b1;
            if (exp_flushe_now) exp_flush_cnt = exp_flush_cnt + 1'b1;
            if (frz_now) begin
                busy++;
                if (busy >= MEM_TIMEOUT) halted = 1'b1;
            end else begin
                busy = 0;
            end
        end
    endtask

    // Inputs are applied just after a falling edge; outputs are sampled 1 time unit later.
    task automatic step();
        #1;
        check_cycle();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out", {hif.stallF, hif.stallD, hif.stallE, hif.stallM, hif.flushD,
                          hif.flushE, hif.flushW, hif.forwardAE, hif.forwardBE, hif.halt}, '0);
        check("rst_state", dbg_state, 2'd0);
`ifdef HAZ_PERF_CNT_EN
        check("rst_perf", {hif.perf_stall_cnt, hif.perf_flush_cnt}, '0);
`endif
        busy = 0;
        halted = 1'b0;
        exp_stall_cnt = '0;
        exp_flush_cnt = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        hif.RdE = 5'd3; hif.result_src0E = 1; hif.Rs1D = 5'd3; hif.PC_srcE = 1;
        @(negedge clk);
        do_reset();
        idle();

        // Forwarding: M beats W, then W when M no longer matches.
        hif.Rs1E = 5; hif.RdM = 5; hif.reg_writeM = 1; hif.RdW = 5; hif.reg_writeW = 1;
        #1 check("s1_fwd_m", hif.forwardAE, 2'b10);
        step();
        hif.RdM = 0;
        #1 check("s1_fwd_w", hif.forwardAE, 2'b01);
        step();
        idle();

        // Load-use: one stall cycle, then W forwarding to the dependent instruction.
        hif.RdE = 7; hif.result_src0E = 1; hif.Rs2D = 7;
        #1 check("s2_stall", {hif.stallF, hif.stallD, hif.flushE}, 3'b111);
        step();
        idle();
        hif.RdM = 7; hif.reg_writeM = 1; hif.Rs2D = 7;
        #1 check("s2_no_stall", {hif.stallF, hif.stallD, hif.flushE}, 3'b000);
        step();
        idle();
        hif.RdW = 7; hif.reg_writeW = 1; hif.Rs2E = 7;
        #1 check("s2_fwd_b", hif.forwardBE, 2'b01);
        step();
        idle();

        // Memory wait of three cycles, release on the fourth with a pending branch.
        for (int i = 0; i < 3; i++) begin
            hif.mem_reqM = 1; hif.mem_readyM = 0; hif.PC_srcE = 1;
            #1 check("s4_freeze", {hif.stallF, hif.stallE, hif.stallM, hif.flushW, hif.flushD}, 5'b11110);
            step();
        end
        hif.mem_readyM = 1;
        #1 check("s4_release", {hif.stallF, hif.stallM, hif.flushW, hif.flushD}, 4'b0001);
        step();
        idle();
        check("s4_state_run", dbg_state, 2'd0);
`ifdef HAZ_PERF_CNT_EN
        check("s6_stall_cnt", hif.perf_stall_cnt, 32'd4 + 32'd0);
        check("s6_flush_cnt", hif.perf_flush_cnt, 32'd2);
`endif

        // Branch wins over load-use.
        hif.RdE = 9; hif.result_src0E = 1; hif.Rs1D = 9; hif.PC_srcE = 1;
        #1 check("s3_branch", {hif.flushD, hif.flushE, hif.stallF, hif.stallD}, 4'b1100);
        step();
        idle();

        // Back-to-back not-ready accesses with one RUN cycle between.
        hif.mem_reqM = 1; hif.mem_readyM = 0; step();
        hif.mem_readyM = 1; step();
        hif.mem_readyM = 0;
        #1 check("b2b_state_run", dbg_state, 2'd0);
        step();
        check("b2b_state_wait", dbg_state, 2'd1);
        hif.mem_readyM = 1; step();
        idle();

        // Timeout: memory stays not-ready, core halts and stays frozen until reset.
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            hif.mem_reqM = 1; hif.mem_readyM = 0;
            step();
        end
        check("s5_halt", hif.halt, 1'b1);
        hif.mem_readyM = 1;
        #1 check("s5_halt_stalls", {hif.stallF, hif.stallD, hif.stallE, hif.stallM, hif.flushW}, 5'b11111);
        step();
        step();
        do_reset();
        idle();
        #1 check("s5_after_rst", {dbg_state, hif.halt}, 3'b000);
        step();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            hif.Rs1D = 5'($urandom_range(0, 3));
            hif.Rs2D = 5'($urandom_range(0, 3));
            hif.Rs1E = 5'($urandom_range(0, 3));
            hif.Rs2E = 5'($urandom_range(0, 3));
            hif.RdE = 5'($urandom_range(0, 3));
            hif.RdM = 5'($urandom_range(0, 3));
            hif.RdW = 5'($urandom_range(0, 3));
            hif.reg_writeM = 1'($urandom_range(0, 1));
            hif.reg_writeW = 1'($urandom_range(0, 1));
            hif.result_src0E = ($urandom_range(0, 9) < 3);
            hif.PC_srcE = ($urandom_range(0, 9) < 2);
            hif.mem_reqM = ($urandom_range(0, 9) < 4);
            hif.mem_readyM = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 199) == 0 || (halted && $urandom_range(0, 3) == 0)) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
